ssd_capture: RTL
================

SSD_CAPTURE -- requirements
Module: ssd_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 16, meaning consecutive cycles the synchronized bus must hold before it is sampled (legal range 2..65535).
REQ-002 The block SHALL have parameter TIMEOUT, default 262144, meaning cycles without a refresh of a position before that position is invalidated.
REQ-003 clk  input  1  system clock; the block uses one clock.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 a, b, c, d, e, f, g  input  1 each  segment lines, active-low, from an external multiplexed display driver.
REQ-006 an  input  4  anode enables, active-low; bit k selects position k (bit 0 is rightmost).
REQ-007 digit0, digit1, digit2, digit3  output  4 each  last decoded hex value per position.
REQ-008 valid  output  4  bit k high means digitk holds a decode that is recognized and not stale.
REQ-009 blank  output  4  bit k high means position k was last sampled with all segments off.
REQ-010 frame_done  output  1  one-cycle pulse when all four positions have been sampled since the previous pulse.
REQ-011 seg_err  output  1  one-cycle pulse when a sampled segment pattern is unrecognized.
REQ-012 an_err  output  1  one-cycle pulse when a sampled anode pattern has more than one bit low.

Function
REQ-013 All 11 inputs {a..g, an} SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 A stability counter SHALL reset to 0 on any cycle where the synchronized bus differs from its value in the previous cycle, and SHALL otherwise increment, saturating.
REQ-015 A single sample strobe SHALL fire in the cycle the counter reaches STABLE_CYCLES-1, and SHALL fire only once per stable period.
REQ-016 Outputs SHALL update on the clock edge at the end of the strobe cycle, giving a latency of 2+STABLE_CYCLES cycles from an input change.
REQ-017 Decode (pattern {a,b,c,d,e,f,g} -> value): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F.
REQ-018 On a strobe with exactly one an bit k low and a matching pattern, the block SHALL set digitk to the value, valid[k] to 1 and blank[k] to 0.
REQ-019 On a strobe with exactly one an bit k low and pattern 1111111, the block SHALL set blank[k] to 1 and valid[k] to 0, and digitk SHALL hold.
REQ-020 On a strobe with exactly one an bit k low and any other pattern, the block SHALL pulse seg_err, set valid[k] to 0 and blank[k] to 0, and digitk SHALL hold.
REQ-021 On a strobe with an = 1111, no outputs SHALL change and no error SHALL be raised.
REQ-022 On a strobe with two or more an bits low, the block SHALL pulse an_err and change no digit, valid or blank bit.
REQ-023 A seen[3:0] register SHALL set bit k on any strobe for single-low position k covered by REQ-018, REQ-019 or REQ-020.
REQ-024 When seen reaches 1111, frame_done SHALL pulse for 1 cycle and seen SHALL clear in the same edge; a strobe arriving in that cycle SHALL count toward the next frame.
REQ-025 Each position SHALL have a staleness counter that clears on a strobe for that position, increments otherwise, and saturates.
REQ-026 When a staleness counter reaches TIMEOUT-1, valid[k] SHALL clear while digitk and blank[k] hold.
REQ-027 The stability counter SHALL be 16 bits wide and each staleness counter SHALL be ceil(log2(TIMEOUT+1)) bits wide; none SHALL wrap.

Reset
REQ-028 Asserting rst SHALL immediately set digit0-3 to 0, valid, blank and seen to 0000, frame_done, seg_err and an_err to 0, and all counters to 0.
REQ-029 Asserting rst SHALL set the synchronizer flops to all-ones (idle bus), so that no strobe updates outputs after release.
REQ-030 A rst asserted mid-stable-period SHALL discard the pending sample.

Verification
REQ-031 an=1110, segs=0010010 held for 40 cycles -> digit0=2 and valid=0001 after exactly 18 cycles, with one strobe only.
REQ-032 Drive positions 0-3 with 1,A,F,blank for 20 cycles each, in order -> digits 1,A,F,held; valid=0111; blank=1000; one frame_done pulse after the 4th position.
REQ-033 Segments toggled every 5 cycles with STABLE_CYCLES=16 -> no output change and no pulses.
REQ-034 an=1100 stable -> one an_err pulse; an=1110 with segs=1111110 -> one seg_err pulse and valid[0]=0.
REQ-035 With TIMEOUT=1000, position 2 is valid and then not driven -> valid[2]=0 at 1000 cycles after its last strobe, with digit2 unchanged.
REQ-036 rst pulsed mid-stable-period -> all outputs reset and no update follows from the interrupted sample.

Source files
------------

// File: rtl/ssd_capture_if.sv
// Bus between a multiplexed seven-segment display driver and the capture block.
// The driver side (master) owns the active-low segment and anode lines; the
// capture side (slave) owns the decoded digits, status bits and event pulses.
// Segment/anode lines are level signals with no handshake: the capture block
// treats them as asynchronous and only samples them once they have held still.
interface ssd_capture_if;
    logic       a, b, c, d, e, f, g;
    logic [3:0] an;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] valid;
    logic [3:0] blank;
    logic       frame_done;
    logic       seg_err;
    logic       an_err;

    modport master (
        output a, b, c, d, e, f, g, an,
        input  digit0, digit1, digit2, digit3, valid, blank,
        input  frame_done, seg_err, an_err
    );

    modport slave (
        input  a, b, c, d, e, f, g, an,
        output digit0, digit1, digit2, digit3, valid, blank,
        output frame_done, seg_err, an_err
    );
endinterface

// File: rtl/ssd_capture.sv
// Snoops a multiplexed 4-digit seven-segment display bus and recovers the hex
// value shown at each position. The bus is synchronized, debounced by a
// stability counter, and sampled once per stable period.
module ssd_capture #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned TIMEOUT       = 262144
) (
    input logic         clk,
    input logic         rst,
    ssd_capture_if.slave bus
);
    localparam int unsigned SW        = $clog2(TIMEOUT + 1);
    localparam logic [15:0] STROBE_AT = 16'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STALE_AT = SW'(TIMEOUT - 1);

    logic [10:0]   raw, sync1, sync2;
    logic [15:0]   stab_cnt;
    logic          strobe;
    logic [6:0]    seg_pat;
    logic [3:0]    an_low;
    logic          one_low, multi_low, is_blank;
    logic          dec_hit;
    logic [3:0]    dec_val;
    logic [3:0]    hit;
    logic [3:0]    seen;
    logic [3:0]    digit [4];
    logic [SW-1:0] stale [4];

    assign raw = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.an};

    // Two-flop synchronizer; resets to the idle (all-off) bus pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Stability counter: the value held in a cycle is the number of cycles the
    // synchronized bus has been unchanged. Comparing sync1 against sync2 sees
    // the change one edge early, so the count is already 0 in the first cycle
    // the new value sits in sync2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt <= '0;
        end else if (sync1 != sync2) begin
            stab_cnt <= '0;
        end else if (stab_cnt != 16'hFFFF) begin
            stab_cnt <= stab_cnt + 16'd1;
        end
    end

    // Saturation keeps the counter from ever returning to STROBE_AT, so one
    // strobe per stable period.
    assign strobe    = (stab_cnt == STROBE_AT);
    assign seg_pat   = sync2[10:4];
    assign an_low    = ~sync2[3:0];
    assign one_low   = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
    assign multi_low = (an_low != 4'd0) && !one_low;
    assign is_blank  = (seg_pat == 7'b1111111);
    assign hit       = (strobe && one_low) ? an_low : 4'd0;

    // Active-low segment pattern {a..g} to hex value.
    always_comb begin
        dec_hit = 1'b1;
        dec_val = 4'h0;
        case (seg_pat)
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001111: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
            default:    dec_hit = 1'b0;
        endcase
    end

    // Per-position staleness counters, cleared whenever that position is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) stale[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (hit[k]) begin
                    stale[k] <= '0;
                end else if (stale[k] != {SW{1'b1}}) begin
                    stale[k] <= stale[k] + SW'(1);
                end
            end
        end
    end

    // Position state, frame tracking and error pulses. A sample at a position
    // overrides a timeout reached in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) digit[k] <= '0;
            bus.valid      <= '0;
            bus.blank      <= '0;
            seen           <= '0;
            bus.frame_done <= 1'b0;
            bus.seg_err    <= 1'b0;
            bus.an_err     <= 1'b0;
        end else begin
            bus.frame_done <= (seen == 4'hF);
            seen           <= ((seen == 4'hF) ? 4'h0 : seen) | hit;
            bus.seg_err    <= (hit != 4'd0) && !is_blank && !dec_hit;
            bus.an_err     <= strobe && multi_low;
            for (int k = 0; k < 4; k++) begin
                if (hit[k]) begin
                    if (is_blank) begin
                        bus.blank[k] <= 1'b1;
                        bus.valid[k] <= 1'b0;
                    end else if (dec_hit) begin
                        digit[k]     <= dec_val;
                        bus.valid[k] <= 1'b1;
                        bus.blank[k] <= 1'b0;
                    end else begin
                        bus.valid[k] <= 1'b0;
                        bus.blank[k] <= 1'b0;
                    end
                end else if (stale[k] == STALE_AT) begin
                    bus.valid[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.digit0 = digit[0];
    assign bus.digit1 = digit[1];
    assign bus.digit2 = digit[2];
    assign bus.digit3 = digit[3];
endmodule
